line_fifo_scheduler: RTL and testbench
======================================

# line_fifo_scheduler

Owns the single shared line-option FIFO and sequences the board phases. It grants the FIFO write port to the parser during RECEIVE and to the solver during SOLVE, and gates solver reads. It tracks FIFO occupancy, flushes the FIFO between boards, and aborts a solve that has stopped making progress. It sits between parser/solver and the `fifo_11_by_11` IP, and replaces the ad-hoc write mux and phase register in `top_level`.

## Interface
Parameters:
- `LINE_W`, 16: width of one encoded line option.
- `DEPTH`, 2048: FIFO IP depth in entries.
- `STALL_CYCLES`, 1_000_000: SOLVE cycles without progress before abort (20 ms at 50 MHz).

Ports:
- `clk_50mhz`, in, 1: clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `parsed`, in, 1: parser board-done pulse.
- `solved`, in, 1: solver done pulse.
- `assembled`, in, 1: assembler done pulse.
- `parse_write`, in, 1: parser write request.
- `parse_line`, in, LINE_W: parser write data.
- `solve_write`, in, 1: solver write-back request.
- `solve_line`, in, LINE_W: solver write-back data.
- `solve_next`, in, 1: solver read request.
- `solve_progress`, in, 1: solver pulse, a new cell became known.
- `fifo_empty`, in, 1: from the FIFO IP.
- `fifo_full`, in, 1: from the FIFO IP.
- `fifo_wr_en`, out, 1: to the IP.
- `fifo_din`, out, LINE_W: to the IP.
- `fifo_rd_en`, out, 1: to the IP.
- `fifo_flush`, out, 1: drives the IP `srst`.
- `solver_start`, out, 1: one-cycle pulse that starts the solver.
- `phase`, out, 2: RECEIVE=0, SOLVE=1, TRANSMIT=2, ERROR=3.
- `occupancy`, out, $clog2(DEPTH+1): accepted entries not yet read.
- `overflow`, out, 1: sticky flag.
- `misroute`, out, 1: sticky flag.
- `stalled`, out, 1: sticky flag.

## Operation
- **Phase FSM.**
  - RECEIVE: on `parsed`, go to SOLVE if `occupancy`>0, else go to ERROR.
  - SOLVE: on `solved`, go to TRANSMIT. On watchdog expiry, set `stalled` and go to ERROR.
  - TRANSMIT: on `assembled`, go to RECEIVE and issue a flush.
  - ERROR: held until `rst`.
- **Write grant.** Only the phase owner may write: parser in RECEIVE, solver in SOLVE. A request from a non-owner, or any request in TRANSMIT/ERROR, is dropped and sets `misroute`.
- **Write acceptance.** An owner request is accepted if `occupancy`<DEPTH, or if a read is accepted in the same cycle. Otherwise it is dropped and sets `overflow`. `fifo_full` asserting while `fifo_wr_en` is high also sets `overflow`.
- **Read gate.** `fifo_rd_en = solve_next & ~fifo_empty & (phase==SOLVE)`. This path is combinational, because the solver consumes the IP's first-word-fall-through `dout`. A read request while the FIFO is empty is ignored and is not counted.
- **Occupancy.**
  - +1 on an accepted write, -1 on an accepted read; a write and a read in the same cycle leave it unchanged.
  - It never wraps: saturates at DEPTH and at 0.
  - It is cleared by a flush.
- **Watchdog.**
  - The counter runs only in SOLVE.
  - It clears on `solve_progress`, on `solved`, and on SOLVE entry.
  - The abort fires when the counter reaches STALL_CYCLES-1.
- **Flush.** `fifo_flush` is high during `rst` and for exactly 1 cycle after TRANSMIT→RECEIVE. That cycle also clears `occupancy`, `overflow` and `misroute`. `stalled` is cleared only by `rst`.

## Timing
- **Reset values.**
  - `phase`=RECEIVE, `fifo_flush`=1.
  - `fifo_wr_en`=0, `fifo_din`=0, `solver_start`=0.
  - `occupancy`=0, all sticky flags 0.
  - `fifo_rd_en` is 0 because it is gated by phase.
- **Write path.** Registered. A request accepted in cycle t gives `fifo_wr_en`/`fifo_din` in cycle t+1. `occupancy` updates in cycle t+1.
- **Read path.** Zero latency; `occupancy` updates in the following cycle.
- **Phase change.** Registered, one cycle after the qualifying pulse. `solver_start` pulses in the first cycle of SOLVE.
- **Simultaneous events.**
  - `parsed` together with a final `parse_write`: the write is accepted, and that write counts toward the `occupancy`>0 check.
  - `solved` together with watchdog expiry: `solved` wins.
  - `solve_write` in the cycle of `solved`: accepted.
- **Reset mid-operation.** `rst` in any phase gives RECEIVE with the FIFO flushed. No pending write is issued after reset.

## Structure
- Shared package `nonogram_pkg` holds:
  - the `phase_t` enum (RECEIVE, SOLVE, TRANSMIT, ERROR);
  - `LINE_W`;
  - the `DEPTH` default.
- `top_level`'s `state` is replaced by `phase` from this block.
- One sub-module, `fifo_occupancy_counter`. It takes the accept-write, accept-read and clear signals, and outputs a saturating count and `at_full`.

## Test plan
- **RECEIVE writes and hand-off.** 22 `parse_write`s, then `parsed`.
  - `occupancy`=22.
  - `phase`=SOLVE one cycle later.
  - `solver_start` is a single pulse.
- **SOLVE read/write-back.** In SOLVE, `solve_next` and `solve_write` together for 10 cycles: `occupancy` stays 22, with 10 `fifo_rd_en` and 10 `fifo_wr_en`.
- **Misroute.** `solve_write` during RECEIVE: `fifo_wr_en` stays 0, `misroute`=1, `occupancy` unchanged.
- **Overflow.** Fill to DEPTH, then one more `solve_write` with no read: the write is dropped, `overflow`=1, `occupancy`=DEPTH.
- **Watchdog.** STALL_CYCLES=100, no `solve_progress`: `stalled`=1 and `phase`=ERROR after 100 SOLVE cycles. A `solve_progress` at cycle 99 prevents the abort.
- **End of board and reset.** `assembled` gives RECEIVE, one `fifo_flush` cycle, `occupancy`=0. `rst` mid-SOLVE gives RECEIVE with flush asserted.

Source files
------------

// File: rtl/nonogram_pkg.sv
// Shared types and sizing for the nonogram datapath.
// Board phases are shared by the scheduler, top_level and the bench.
package nonogram_pkg;

    typedef enum logic [1:0] {
        RECEIVE  = 2'd0,
        SOLVE    = 2'd1,
        TRANSMIT = 2'd2,
        ERROR    = 2'd3
    } phase_t;

    localparam int LINE_W        = 16;
    localparam int DEPTH_DEFAULT = 2048;

endpackage

// File: rtl/fifo_occupancy_counter.sv
// Saturating count of entries accepted into the line FIFO and not yet read.
// A simultaneous write and read cancel; the count never wraps past 0 or DEPTH.
module fifo_occupancy_counter #(
    parameter int DEPTH = nonogram_pkg::DEPTH_DEFAULT
) (
    input  logic                         clk_50mhz,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         inc,
    input  logic                         dec,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         at_full
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);

    always_ff @(posedge clk_50mhz) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && !dec && count != FULL_COUNT) begin
            count <= count + OCC_W'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - OCC_W'(1);
        end
    end

    assign at_full = (count == FULL_COUNT);

endmodule

// File: rtl/line_fifo_scheduler.sv
// Owns the shared line-option FIFO: grants its write port per board phase,
// gates solver reads, tracks occupancy, flushes between boards and aborts stalled solves.
module line_fifo_scheduler #(
    parameter int LINE_W       = nonogram_pkg::LINE_W,
    parameter int DEPTH        = nonogram_pkg::DEPTH_DEFAULT,
    parameter int STALL_CYCLES = 1_000_000
) (
    input  logic                        clk_50mhz,
    input  logic                        rst,
    input  logic                        parsed,
    input  logic                        solved,
    input  logic                        assembled,
    input  logic                        parse_write,
    input  logic [LINE_W-1:0]           parse_line,
    input  logic                        solve_write,
    input  logic [LINE_W-1:0]           solve_line,
    input  logic                        solve_next,
    input  logic                        solve_progress,
    input  logic                        fifo_empty,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [LINE_W-1:0]           fifo_din,
    output logic                        fifo_rd_en,
    output logic                        fifo_flush,
    output logic                        solver_start,
    output logic [1:0]                  phase,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy,
    output logic                        overflow,
    output logic                        misroute,
    output logic                        stalled
);

    import nonogram_pkg::*;

    localparam int WD_W = $clog2(STALL_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_CYCLES - 1);

    phase_t          state;
    logic [WD_W-1:0] wd_count;
    logic            flush_pending;
    logic            at_full;
    logic            parser_owns;
    logic            solver_owns;
    logic            owner_req;
    logic            non_owner_req;
    logic            accept_wr;
    logic            accept_rd;
    logic            board_done;
    logic            wd_expired;

    assign parser_owns   = (state == RECEIVE);
    assign solver_owns   = (state == SOLVE);
    assign owner_req     = (parse_write & parser_owns) | (solve_write & solver_owns);
    assign non_owner_req = (parse_write & ~parser_owns) | (solve_write & ~solver_owns);

    // The solver consumes first-word-fall-through data, so the read gate stays combinational.
    assign accept_rd  = solve_next & ~fifo_empty & solver_owns;
    assign accept_wr  = owner_req & (~at_full | accept_rd);
    assign board_done = (state == TRANSMIT) & assembled;
    assign wd_expired = solver_owns & ~solved & ~solve_progress & (wd_count == WD_LAST);

    assign fifo_rd_en = accept_rd;
    assign fifo_flush = rst | flush_pending;
    assign phase      = state;

    fifo_occupancy_counter #(
        .DEPTH (DEPTH)
    ) u_occupancy (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .clear     (board_done),
        .inc       (accept_wr),
        .dec       (accept_rd),
        .count     (occupancy),
        .at_full   (at_full)
    );

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state         <= RECEIVE;
            solver_start  <= 1'b0;
            stalled       <= 1'b0;
            flush_pending <= 1'b0;
        end else begin
            solver_start  <= 1'b0;
            flush_pending <= board_done;
            case (state)
                RECEIVE: begin
                    // A final write arriving with parsed still makes the board non-empty.
                    if (parsed) begin
                        if (occupancy != '0 || accept_wr) begin
                            state        <= SOLVE;
                            solver_start <= 1'b1;
                        end else begin
                            state <= ERROR;
                        end
                    end
                end
                SOLVE: begin
                    if (solved) begin
                        state <= TRANSMIT;
                    end else if (wd_expired) begin
                        stalled <= 1'b1;
                        state   <= ERROR;
                    end
                end
                TRANSMIT: begin
                    if (assembled) begin
                        state <= RECEIVE;
                    end
                end
                default: begin
                    state <= ERROR;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst || !solver_owns || solve_progress || solved) begin
            wd_count <= '0;
        end else begin
            wd_count <= wd_count + WD_W'(1);
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
        end else begin
            fifo_wr_en <= accept_wr;
            if (accept_wr) begin
                fifo_din <= parser_owns ? parse_line : solve_line;
            end
        end
    end

    // Sticky error flags survive until the end-of-board flush; stalled only clears on rst.
    always_ff @(posedge clk_50mhz) begin
        if (rst || board_done) begin
            overflow <= 1'b0;
            misroute <= 1'b0;
        end else begin
            overflow <= overflow | (owner_req & ~accept_wr) | (fifo_full & fifo_wr_en);
            misroute <= misroute | non_owner_req;
        end
    end

endmodule

// File: tb/tb_line_fifo_scheduler.sv
// Scoreboard bench for line_fifo_scheduler: directed board scenarios then random traffic,
// with a behavioural FIFO IP and a phase-level reference model.
module tb_line_fifo_scheduler;

    localparam int LINE_W  = 16;
    localparam int DEPTH   = 32;
    localparam int STALL   = 100;
    localparam int OCC_W   = $clog2(DEPTH + 1);
    localparam int P_RECV  = 0;
    localparam int P_SOLVE = 1;
    localparam int P_TX    = 2;
    localparam int P_ERR   = 3;

    logic              clk_50mhz = 1'b0;
    logic              rst = 1'b1;
    logic              parsed = 1'b0;
    logic              solved = 1'b0;
    logic              assembled = 1'b0;
    logic              parse_write = 1'b0;
    logic [LINE_W-1:0] parse_line = '0;
    logic              solve_write = 1'b0;
    logic [LINE_W-1:0] solve_line = '0;
    logic              solve_next = 1'b0;
    logic              solve_progress = 1'b0;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [LINE_W-1:0] fifo_din;
    logic              fifo_rd_en;
    logic              fifo_flush;
    logic              solver_start;
    logic [1:0]        phase;
    logic [OCC_W-1:0]  occupancy;
    logic              overflow;
    logic              misroute;
    logic              stalled;

    always #10 clk_50mhz = ~clk_50mhz;

    line_fifo_scheduler #(
        .LINE_W       (LINE_W),
        .DEPTH        (DEPTH),
        .STALL_CYCLES (STALL)
    ) dut (
        .clk_50mhz      (clk_50mhz),
        .rst            (rst),
        .parsed         (parsed),
        .solved         (solved),
        .assembled      (assembled),
        .parse_write    (parse_write),
        .parse_line     (parse_line),
        .solve_write    (solve_write),
        .solve_line     (solve_line),
        .solve_next     (solve_next),
        .solve_progress (solve_progress),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_din       (fifo_din),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_flush     (fifo_flush),
        .solver_start   (solver_start),
        .phase          (phase),
        .occupancy      (occupancy),
        .overflow       (overflow),
        .misroute       (misroute),
        .stalled        (stalled)
    );

    typedef struct {
        bit              rst;
        bit              pw;
        logic [LINE_W-1:0] pl;
        bit              sw;
        logic [LINE_W-1:0] sl;
        bit              next;
        bit              prog;
        bit              parsed;
        bit              solved;
        bit              assembled;
    } stim_t;

    typedef struct {
        int cyc;
        int phase;
        int occ;
        bit over;
        bit mis;
        bit stall;
        bit start;
        bit flush;
        bit wr;
    } exp_t;

    typedef struct {
        int cyc;
        bit rd;
    } rd_t;

    exp_t              exp_state[$];
    rd_t               exp_rd[$];
    logic [LINE_W-1:0] exp_wr[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n_rd  = 0;
    int n_wr  = 0;

    int m_phase = P_RECV;
    int m_occ   = 0;
    int m_idle  = 0;
    bit m_over  = 0;
    bit m_mis   = 0;
    bit m_stall = 0;
    bit m_start = 0;
    bit m_wr    = 0;
    bit m_flush = 0;

    // Behavioural FIFO IP: outputs are sampled mid-cycle and applied on the next edge.
    logic [LINE_W-1:0] ip_q[$];
    int                ip_cnt = 0;
    bit                l_wr = 0;
    bit                l_rd = 0;
    bit                l_fl = 0;
    logic [LINE_W-1:0] l_din = '0;

    assign fifo_empty = (ip_cnt == 0);
    assign fifo_full  = (ip_cnt >= DEPTH);

    always @(posedge clk_50mhz) begin : ip_model
        bit was_full;
        cyc++;
        if (l_fl) begin
            ip_q.delete();
        end else begin
            was_full = (ip_q.size() >= DEPTH);
            if (l_rd && ip_q.size() > 0) void'(ip_q.pop_front());
            if (l_wr && !was_full) ip_q.push_back(l_din);
        end
        ip_cnt <= ip_q.size();
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    always @(negedge clk_50mhz) begin : monitor
        rd_t  r;
        exp_t e;
        l_wr  = (fifo_wr_en === 1'b1);
        l_rd  = (fifo_rd_en === 1'b1);
        l_fl  = (fifo_flush === 1'b1);
        l_din = fifo_din;
        while (exp_rd.size() > 0 && exp_rd[0].cyc <= cyc) begin
            r = exp_rd.pop_front();
            checkOutput("fifo_rd_en", 32'(fifo_rd_en), 32'(r.rd));
        end
        while (exp_state.size() > 0 && exp_state[0].cyc <= cyc) begin
            e = exp_state.pop_front();
            checkOutput("phase", 32'(phase), 32'(e.phase));
            checkOutput("occupancy", 32'(occupancy), 32'(e.occ));
            checkOutput("overflow", 32'(overflow), 32'(e.over));
            checkOutput("misroute", 32'(misroute), 32'(e.mis));
            checkOutput("stalled", 32'(stalled), 32'(e.stall));
            checkOutput("solver_start", 32'(solver_start), 32'(e.start));
            checkOutput("fifo_flush", 32'(fifo_flush), 32'(e.flush | rst));
            checkOutput("fifo_wr_en", 32'(fifo_wr_en), 32'(e.wr));
        end
        if (fifo_rd_en === 1'b1) n_rd++;
        if (fifo_wr_en === 1'b1) begin
            n_wr++;
            if (exp_wr.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_write at cycle %0d: got fifo_wr_en=1, expected 0", cyc);
            end else begin
                checkOutput("fifo_din", 32'(fifo_din), 32'(exp_wr.pop_front()));
            end
        end
    end

    function automatic stim_t idle_stim();
        stim_t s;
        s.rst = 0; s.pw = 0; s.pl = '0; s.sw = 0; s.sl = '0;
        s.next = 0; s.prog = 0; s.parsed = 0; s.solved = 0; s.assembled = 0;
        return s;
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(99) < p;
    endfunction

    function automatic stim_t random_stim();
        stim_t s;
        s = idle_stim();
        s.pl = LINE_W'($urandom);
        s.sl = LINE_W'($urandom);
        case (m_phase)
            P_RECV: begin
                s.pw = pct(60); s.sw = pct(3); s.parsed = pct(5);
            end
            P_SOLVE: begin
                s.next = pct(50); s.sw = pct(40); s.prog = pct(20);
                s.solved = pct(3); s.pw = pct(3);
            end
            P_TX: begin
                s.assembled = pct(10);
                if (!s.assembled) begin
                    s.pw = pct(3); s.sw = pct(3);
                end
            end
            default: s.rst = pct(5);
        endcase
        if ($urandom_range(999) < 5) s.rst = 1;
        return s;
    endfunction

    // Drives one cycle of inputs and advances the phase-level reference model.
    task automatic applyStimulus(input stim_t s);
        rd_t  r;
        exp_t e;
        bit   rd, own, nonown, acc, done, full_wr;
        int   nph, nocc;
        @(posedge clk_50mhz);
        #1;
        rst = s.rst; parse_write = s.pw; parse_line = s.pl;
        solve_write = s.sw; solve_line = s.sl; solve_next = s.next;
        solve_progress = s.prog; parsed = s.parsed; solved = s.solved;
        assembled = s.assembled;

        rd     = s.next && ip_cnt > 0 && m_phase == P_SOLVE;
        own    = (s.pw && m_phase == P_RECV) || (s.sw && m_phase == P_SOLVE);
        nonown = (s.pw && m_phase != P_RECV) || (s.sw && m_phase != P_SOLVE);
        acc    = own && (m_occ < DEPTH || rd);
        r.cyc = cyc;
        r.rd  = rd;
        exp_rd.push_back(r);

        if (s.rst) begin
            m_phase = P_RECV; m_occ = 0; m_idle = 0; m_over = 0; m_mis = 0;
            m_stall = 0; m_start = 0; m_wr = 0; m_flush = 0;
        end else begin
            done    = (m_phase == P_TX) && s.assembled;
            full_wr = (ip_cnt >= DEPTH) && m_wr;
            if (acc) exp_wr.push_back(m_phase == P_RECV ? s.pl : s.sl);
            if (done) begin
                m_over = 0;
                m_mis  = 0;
            end else begin
                m_over = m_over | (own && !acc) | full_wr;
                m_mis  = m_mis | nonown;
            end
            nocc = done ? 0 : m_occ + int'(acc) - int'(rd);
            if (nocc > DEPTH) nocc = DEPTH;
            if (nocc < 0) nocc = 0;
            m_start = 0;
            nph = m_phase;
            case (m_phase)
                P_RECV: if (s.parsed) begin
                    if (m_occ > 0 || acc) begin
                        nph = P_SOLVE;
                        m_start = 1;
                    end else begin
                        nph = P_ERR;
                    end
                end
                P_SOLVE: begin
                    if (s.solved) nph = P_TX;
                    else if (s.prog) m_idle = 0;
                    else if (m_idle == STALL - 1) begin
                        nph = P_ERR;
                        m_stall = 1;
                    end else m_idle++;
                end
                P_TX: if (s.assembled) nph = P_RECV;
                default: ;
            endcase
            if (nph != P_SOLVE) m_idle = 0;
            m_phase = nph;
            m_occ   = nocc;
            m_wr    = acc;
            m_flush = done;
        end

        e.cyc = cyc + 1; e.phase = m_phase; e.occ = m_occ; e.over = m_over;
        e.mis = m_mis; e.stall = m_stall; e.start = m_start; e.flush = m_flush; e.wr = m_wr;
        exp_state.push_back(e);
    endtask

    initial begin : main
        stim_t s;

        s = idle_stim(); s.rst = 1;
        applyStimulus(s);
        applyStimulus(s);
        @(negedge clk_50mhz); #1;
        checkOutput("reset_phase", 32'(phase), P_RECV);
        checkOutput("reset_flush", 32'(fifo_flush), 1);
        checkOutput("reset_wr_en", 32'(fifo_wr_en), 0);
        checkOutput("reset_rd_en", 32'(fifo_rd_en), 0);
        checkOutput("reset_occupancy", 32'(occupancy), 0);

        // Board 1: 22 parser writes, hand-off, then concurrent read and write-back.
        for (int i = 0; i < 22; i++) begin
            s = idle_stim(); s.pw = 1; s.pl = LINE_W'($urandom);
            applyStimulus(s);
        end
        s = idle_stim(); s.parsed = 1;
        applyStimulus(s);
        applyStimulus(idle_stim());
        @(negedge clk_50mhz); #1;
        checkOutput("handoff_phase", 32'(phase), P_SOLVE);
        checkOutput("handoff_start", 32'(solver_start), 1);
        checkOutput("handoff_occupancy", 32'(occupancy), 22);
        applyStimulus(idle_stim());
        @(negedge clk_50mhz); #1;
        checkOutput("start_single_pulse", 32'(solver_start), 0);
        n_rd = 0;
        n_wr = 0;
        for (int i = 0; i < 10; i++) begin
            s = idle_stim(); s.next = 1; s.sw = 1; s.sl = LINE_W'($urandom);
            applyStimulus(s);
        end
        applyStimulus(idle_stim());
        applyStimulus(idle_stim());
        @(negedge clk_50mhz); #1;
        checkOutput("solve_rd_count", 32'(n_rd), 10);
        checkOutput("solve_wr_count", 32'(n_wr), 10);
        checkOutput("solve_occupancy", 32'(occupancy), 22);

        s = idle_stim(); s.solved = 1;
        applyStimulus(s);
        s = idle_stim(); s.assembled = 1;
        applyStimulus(s);
        applyStimulus(idle_stim());
        @(negedge clk_50mhz); #1;
        checkOutput("eob_phase", 32'(phase), P_RECV);
        checkOutput("eob_flush", 32'(fifo_flush), 1);
        checkOutput("eob_occupancy", 32'(occupancy), 0);
        applyStimulus(idle_stim());
        @(negedge clk_50mhz); #1;
        checkOutput("eob_flush_one_cycle", 32'(fifo_flush), 0);

        s = idle_stim(); s.sw = 1; s.sl = LINE_W'($urandom);
        applyStimulus(s);
        applyStimulus(idle_stim());
        @(negedge clk_50mhz); #1;
        checkOutput("misroute_flag", 32'(misroute), 1);
        checkOutput("misroute_wr_en", 32'(fifo_wr_en), 0);
        checkOutput("misroute_occupancy", 32'(occupancy), 0);

        // Fill to DEPTH, then one write-back with no read must be dropped.
        for (int i = 0; i < DEPTH; i++) begin
            s = idle_stim(); s.pw = 1; s.pl = LINE_W'($urandom);
            applyStimulus(s);
        end
        s = idle_stim(); s.parsed = 1;
        applyStimulus(s);
        s = idle_stim(); s.sw = 1; s.sl = LINE_W'($urandom);
        applyStimulus(s);
        applyStimulus(idle_stim());
        @(negedge clk_50mhz); #1;
        checkOutput("overflow_flag", 32'(overflow), 1);
        checkOutput("overflow_occupancy", 32'(occupancy), DEPTH);
        checkOutput("overflow_wr_en", 32'(fifo_wr_en), 0);

        // Watchdog: progress in SOLVE cycle 99 rescues, 100 idle cycles afterwards abort.
        s = idle_stim(); s.rst = 1;
        applyStimulus(s);
        s = idle_stim(); s.pw = 1; s.pl = LINE_W'($urandom);
        applyStimulus(s);
        s = idle_stim(); s.parsed = 1;
        applyStimulus(s);
        for (int i = 0; i < STALL - 1; i++) applyStimulus(idle_stim());
        s = idle_stim(); s.prog = 1;
        applyStimulus(s);
        for (int i = 0; i < STALL; i++) applyStimulus(idle_stim());
        @(negedge clk_50mhz); #1;
        checkOutput("wd_rescued_phase", 32'(phase), P_SOLVE);
        checkOutput("wd_rescued_stalled", 32'(stalled), 0);
        applyStimulus(idle_stim());
        @(negedge clk_50mhz); #1;
        checkOutput("wd_abort_phase", 32'(phase), P_ERR);
        checkOutput("wd_abort_stalled", 32'(stalled), 1);

        // Reset in the middle of SOLVE, with a write-back requested in the reset cycle.
        s = idle_stim(); s.rst = 1;
        applyStimulus(s);
        for (int i = 0; i < 3; i++) begin
            s = idle_stim(); s.pw = 1; s.pl = LINE_W'($urandom);
            applyStimulus(s);
        end
        s = idle_stim(); s.parsed = 1;
        applyStimulus(s);
        s = idle_stim(); s.next = 1;
        applyStimulus(s);
        s = idle_stim(); s.rst = 1; s.sw = 1; s.sl = LINE_W'($urandom);
        applyStimulus(s);
        @(negedge clk_50mhz); #1;
        checkOutput("midsolve_rst_flush", 32'(fifo_flush), 1);
        applyStimulus(idle_stim());
        @(negedge clk_50mhz); #1;
        checkOutput("midsolve_rst_phase", 32'(phase), P_RECV);
        checkOutput("midsolve_rst_wr_en", 32'(fifo_wr_en), 0);
        checkOutput("midsolve_rst_occupancy", 32'(occupancy), 0);

        for (int i = 0; i < 3000; i++) applyStimulus(random_stim());
        applyStimulus(idle_stim());
        applyStimulus(idle_stim());
        @(negedge clk_50mhz); #1;
        checkOutput("write_scoreboard_drained", 32'(exp_wr.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
